// File: rtl/man_swap_pipe.sv
// Two-stage pipelined mantissa swap for the FP add/sub datapath.
// S1 compares magnitudes, S2 orders the operands and computes the exponent difference.
module man_swap_pipe #(
    parameter int SIZE_EXP  = 8,
    parameter int SIZE_MAN  = 28,
    parameter int SIZE_DIFF = SIZE_EXP
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_op_sub,
    input  logic                 i_sign_a,
    input  logic                 i_sign_b,
    input  logic [SIZE_EXP-1:0]  i_exp_a,
    input  logic [SIZE_EXP-1:0]  i_exp_b,
    input  logic [SIZE_MAN-1:0]  i_man_a,
    input  logic [SIZE_MAN-1:0]  i_man_b,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_sign_max,
    output logic [SIZE_EXP-1:0]  o_exp_max,
    output logic [SIZE_MAN-1:0]  o_man_max,
    output logic [SIZE_MAN-1:0]  o_man_min,
    output logic [SIZE_DIFF-1:0] o_exp_diff,
    output logic                 o_align_ovf,
    output logic                 o_eff_sub,
    output logic                 o_swapped
);

    logic                s1_valid;
    logic                s2_valid;
    logic                en1;
    logic                en2;
    logic                lt_in;

    logic                s1_lt;
    logic                s1_eff_sub;
    logic                s1_sign_a;
    logic                s1_sign_b_eff;
    logic [SIZE_EXP-1:0] s1_exp_a;
    logic [SIZE_EXP-1:0] s1_exp_b;
    logic [SIZE_MAN-1:0] s1_man_a;
    logic [SIZE_MAN-1:0] s1_man_b;

    logic                sign_max_w;
    logic [SIZE_EXP-1:0] exp_max_w;
    logic [SIZE_EXP-1:0] exp_min_w;
    logic [SIZE_MAN-1:0] man_max_w;
    logic [SIZE_MAN-1:0] man_min_w;
    logic [SIZE_EXP-1:0] exp_diff_w;

    // A stage may load when it is empty or its contents move on this cycle.
    assign en2     = !s2_valid || i_ready;
    assign en1     = !s1_valid || en2;
    assign o_ready = en1;
    assign o_valid = s2_valid;

    // Equal magnitudes give lt = 0, so a keeps the max slot.
    assign lt_in = (i_exp_a < i_exp_b) || ((i_exp_a == i_exp_b) && (i_man_a < i_man_b));

    always_comb begin
        sign_max_w = s1_sign_a;
        exp_max_w  = s1_exp_a;
        exp_min_w  = s1_exp_b;
        man_max_w  = s1_man_a;
        man_min_w  = s1_man_b;
        if (s1_lt) begin
            sign_max_w = s1_sign_b_eff;
            exp_max_w  = s1_exp_b;
            exp_min_w  = s1_exp_a;
            man_max_w  = s1_man_b;
            man_min_w  = s1_man_a;
        end
        // exp_max >= exp_min by construction, so this never wraps.
        exp_diff_w = exp_max_w - exp_min_w;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; data registers are reset too so outputs are never X.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid      <= 1'b0;
            s1_lt         <= 1'b0;
            s1_eff_sub    <= 1'b0;
            s1_sign_a     <= 1'b0;
            s1_sign_b_eff <= 1'b0;
            s1_exp_a      <= '0;
            s1_exp_b      <= '0;
            s1_man_a      <= '0;
            s1_man_b      <= '0;
        end else if (en1) begin
            s1_valid      <= i_valid;
            s1_lt         <= lt_in;
            s1_eff_sub    <= i_sign_a ^ i_sign_b ^ i_op_sub;
            s1_sign_a     <= i_sign_a;
            s1_sign_b_eff <= i_sign_b ^ i_op_sub;
            s1_exp_a      <= i_exp_a;
            s1_exp_b      <= i_exp_b;
            s1_man_a      <= i_man_a;
            s1_man_b      <= i_man_b;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2_valid    <= 1'b0;
            o_sign_max  <= 1'b0;
            o_exp_max   <= '0;
            o_man_max   <= '0;
            o_man_min   <= '0;
            o_exp_diff  <= '0;
            o_align_ovf <= 1'b0;
            o_eff_sub   <= 1'b0;
            o_swapped   <= 1'b0;
        end else if (en2) begin
            s2_valid    <= s1_valid;
            o_sign_max  <= sign_max_w;
            o_exp_max   <= exp_max_w;
            o_man_max   <= man_max_w;
            o_man_min   <= man_min_w;
            o_exp_diff  <= SIZE_DIFF'(exp_diff_w);
            o_align_ovf <= (int'(exp_diff_w) >= SIZE_MAN);
            o_eff_sub   <= s1_eff_sub;
            o_swapped   <= s1_lt;
        end
    end

endmodule

// File: tb/tb_man_swap_pipe.sv
// Bench for man_swap_pipe: directed vectors plus random traffic against a
// magnitude-ordering reference model and an occupancy-based timing model.
module tb_man_swap_pipe;

    localparam int SE = 8;
    localparam int SM = 28;

    typedef struct {
        logic          op;
        logic          sa;
        logic          sb;
        logic [SE-1:0] ea;
        logic [SE-1:0] eb;
        logic [SM-1:0] ma;
        logic [SM-1:0] mb;
        int            acc;
    } item_t;

    typedef struct {
        logic          sign_max;
        logic [SE-1:0] exp_max;
        logic [SM-1:0] man_max;
        logic [SM-1:0] man_min;
        logic [SE-1:0] exp_diff;
        logic          ovf;
        logic          eff_sub;
        logic          swapped;
    } out_t;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_valid;
    logic          o_ready;
    logic          i_op_sub;
    logic          i_sign_a;
    logic          i_sign_b;
    logic [SE-1:0] i_exp_a;
    logic [SE-1:0] i_exp_b;
    logic [SM-1:0] i_man_a;
    logic [SM-1:0] i_man_b;
    logic          o_valid;
    logic          i_ready;
    logic          o_sign_max;
    logic [SE-1:0] o_exp_max;
    logic [SM-1:0] o_man_max;
    logic [SM-1:0] o_man_min;
    logic [SE-1:0] o_exp_diff;
    logic          o_align_ovf;
    logic          o_eff_sub;
    logic          o_swapped;

    always #5 clk = ~clk;

    man_swap_pipe #(.SIZE_EXP(SE), .SIZE_MAN(SM), .SIZE_DIFF(SE)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_op_sub(i_op_sub), .i_sign_a(i_sign_a), .i_sign_b(i_sign_b),
        .i_exp_a(i_exp_a), .i_exp_b(i_exp_b), .i_man_a(i_man_a), .i_man_b(i_man_b),
        .o_valid(o_valid), .i_ready(i_ready), .o_sign_max(o_sign_max),
        .o_exp_max(o_exp_max), .o_man_max(o_man_max), .o_man_min(o_man_min),
        .o_exp_diff(o_exp_diff), .o_align_ovf(o_align_ovf), .o_eff_sub(o_eff_sub),
        .o_swapped(o_swapped)
    );

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    n_out = 0;
    item_t q[$];
    out_t  last_out;
    bit    zero_chk = 1'b0;
    bit    last_acc = 1'b0;
    bit    seen_nready = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: order by the whole magnitude {exp, man} as one unsigned number.
    function automatic out_t model(input item_t it);
        out_t           r;
        logic [SE+SM-1:0] mag_a;
        logic [SE+SM-1:0] mag_b;
        int             diff;
        mag_a = {it.ea, it.ma};
        mag_b = {it.eb, it.mb};
        r.swapped = (mag_b > mag_a);
        r.eff_sub = it.sa ^ it.sb ^ it.op;
        if (r.swapped) begin
            r.sign_max = it.sb ^ it.op;
            r.exp_max  = it.eb;
            r.man_max  = it.mb;
            r.man_min  = it.ma;
            diff       = int'(it.eb) - int'(it.ea);
        end else begin
            r.sign_max = it.sa;
            r.exp_max  = it.ea;
            r.man_max  = it.ma;
            r.man_min  = it.mb;
            diff       = int'(it.ea) - int'(it.eb);
        end
        r.exp_diff = SE'(diff);
        r.ovf      = (diff >= SM);
        return r;
    endfunction

    task automatic present(input logic v, input logic op, input logic sa, input logic [SE-1:0] ea,
                           input logic [SM-1:0] ma, input logic sb, input logic [SE-1:0] eb,
                           input logic [SM-1:0] mb);
        i_valid = v; i_op_sub = op;
        i_sign_a = sa; i_exp_a = ea; i_man_a = ma;
        i_sign_b = sb; i_exp_b = eb; i_man_b = mb;
    endtask

    // One clock: check outputs at the falling edge, then advance the model at the rising edge.
    task automatic tick();
        out_t  e;
        out_t  obs;
        item_t it;
        logic  exp_ready;
        logic  exp_valid;
        bit    acc;
        bit    dq;
        @(negedge clk);
        exp_ready = (q.size() < 2) || i_ready;
        exp_valid = (q.size() > 0) && (cyc >= q[0].acc + 2);
        chk("o_ready", o_ready, exp_ready);
        chk("o_valid", o_valid, exp_valid);
        if (!o_ready) seen_nready = 1'b1;
        obs.sign_max = o_sign_max; obs.exp_max = o_exp_max; obs.man_max = o_man_max;
        obs.man_min = o_man_min; obs.exp_diff = o_exp_diff; obs.ovf = o_align_ovf;
        obs.eff_sub = o_eff_sub; obs.swapped = o_swapped;
        chk("no_x", $isunknown({o_sign_max, o_exp_max, o_man_max, o_man_min, o_exp_diff,
                                o_align_ovf, o_eff_sub, o_swapped}), 0);
        if (exp_valid) begin
            e = model(q[0]);
            chk("sign_max", obs.sign_max, e.sign_max);
            chk("exp_max", obs.exp_max, e.exp_max);
            chk("man_max", obs.man_max, e.man_max);
            chk("man_min", obs.man_min, e.man_min);
            chk("exp_diff", obs.exp_diff, e.exp_diff);
            chk("align_ovf", obs.ovf, e.ovf);
            chk("eff_sub", obs.eff_sub, e.eff_sub);
            chk("swapped", obs.swapped, e.swapped);
        end else if (zero_chk) begin
            chk("rst_zero", {o_sign_max, o_exp_max, o_man_max, o_man_min, o_exp_diff,
                             o_align_ovf, o_eff_sub, o_swapped}, 0);
        end
        acc = i_valid && exp_ready && !i_rst;
        dq  = exp_valid && i_ready && !i_rst;
        it.op = i_op_sub; it.sa = i_sign_a; it.sb = i_sign_b;
        it.ea = i_exp_a; it.eb = i_exp_b; it.ma = i_man_a; it.mb = i_man_b; it.acc = cyc;
        @(posedge clk);
        last_acc = acc;
        if (i_rst) begin
            q.delete();
            zero_chk = 1'b1;
        end else begin
            zero_chk = 1'b0;
            if (dq) begin
                last_out = obs;
                void'(q.pop_front());
                n_out++;
            end
            if (acc) q.push_back(it);
        end
        cyc++;
        #1;
    endtask

    // Hold the presented item until it is accepted.
    task automatic send(input logic op, input logic sa, input logic [SE-1:0] ea, input logic [SM-1:0] ma,
                        input logic sb, input logic [SE-1:0] eb, input logic [SM-1:0] mb);
        int n;
        present(1'b1, op, sa, ea, ma, sb, eb, mb);
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 30);
        if (!last_acc) chk("send_timeout", 1, 0);
    endtask

    task automatic drain();
        int n;
        i_valid = 1'b0;
        i_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 30) begin
            tick();
            n++;
        end
        if (q.size() > 0) chk("drain_timeout", q.size(), 0);
        tick();
    endtask

    task automatic chk_out(input string tag, input logic sw, input logic sm, input logic es,
                           input logic [SE-1:0] diff, input logic ovf);
        chk({tag, "_swapped"}, last_out.swapped, sw);
        chk({tag, "_sign_max"}, last_out.sign_max, sm);
        chk({tag, "_eff_sub"}, last_out.eff_sub, es);
        chk({tag, "_exp_diff"}, last_out.exp_diff, diff);
        chk({tag, "_ovf"}, last_out.ovf, ovf);
    endtask

    initial begin
        int base;
        int k;
        int idx;
        i_rst = 1'b1;
        i_ready = 1'b1;
        present(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        tick();
        tick();
        i_rst = 1'b0;
        tick();

        // Swap decided by exponent.
        send(1'b0, 1'b0, 8'h80, 28'h8000000, 1'b0, 8'h85, 28'h8000000);
        drain();
        chk_out("exp_swap", 1'b1, 1'b0, 1'b0, 8'd5, 1'b0);
        chk("exp_swap_exp_max", last_out.exp_max, 8'h85);
        chk("exp_swap_man_max", last_out.man_max, 28'h8000000);
        chk("exp_swap_man_min", last_out.man_min, 28'h8000000);

        // Exponent tie, mantissa decides, subtract flips b's sign.
        send(1'b1, 1'b0, 8'h7F, 28'h9000000, 1'b0, 8'h7F, 28'hA000000);
        drain();
        chk_out("man_tie", 1'b1, 1'b1, 1'b1, 8'd0, 1'b0);

        // Exactly equal magnitudes: no swap.
        send(1'b0, 1'b1, 8'h7F, 28'hC000000, 1'b1, 8'h7F, 28'hC000000);
        drain();
        chk_out("equal", 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);

        // Two zeros.
        send(1'b0, 1'b0, 8'h00, 28'h0, 1'b0, 8'h00, 28'h0);
        drain();
        chk_out("zeros", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

        // Alignment-overflow boundary.
        send(1'b0, 1'b0, 8'h9E, 28'h8000000, 1'b0, 8'h80, 28'h8000000);
        drain();
        chk_out("ovf30", 1'b0, 1'b0, 1'b0, 8'd30, 1'b1);
        send(1'b0, 1'b0, 8'h9E, 28'h8000000, 1'b0, 8'h82, 28'h8000000);
        drain();
        chk_out("ovf28", 1'b0, 1'b0, 1'b0, 8'd28, 1'b1);
        send(1'b0, 1'b0, 8'h9E, 28'h8000000, 1'b0, 8'h83, 28'h8000000);
        drain();
        chk_out("ovf27", 1'b0, 1'b0, 1'b0, 8'd27, 1'b0);

        // Back-pressure: four items streamed, downstream stalls for four cycles.
        base = n_out;
        seen_nready = 1'b0;
        idx = 0;
        k = 1;
        while ((idx < 4 || q.size() > 0) && k < 60) begin
            i_ready = !(k >= 3 && k <= 6);
            if (idx < 4)
                present(1'b1, idx[0], idx[1], 8'(8'h70 + idx * 3), 28'(28'h8100000 + idx),
                        1'b0, 8'(8'h78 - idx * 2), 28'h8800000);
            else
                i_valid = 1'b0;
            tick();
            if (last_acc) idx++;
            k++;
        end
        chk("bp_count", n_out - base, 4);
        chk("bp_ready_low", seen_nready, 1'b1);
        drain();

        // Reset with two items in flight, neither may emerge.
        base = n_out;
        i_ready = 1'b0;
        send(1'b0, 1'b0, 8'h10, 28'h1234567, 1'b1, 8'h20, 28'h7654321);
        send(1'b1, 1'b1, 8'h30, 28'h0ABCDEF, 1'b0, 8'h30, 28'h0ABCDEE);
        present(1'b1, 1'b0, 1'b0, 8'h55, 28'h5555555, 1'b0, 8'h44, 28'h4444444);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("rst_discard", n_out - base, 0);
        send(1'b0, 1'b0, 8'h40, 28'h8000001, 1'b1, 8'h41, 28'h8000000);
        drain();
        chk("rst_after_count", n_out - base, 1);
        chk_out("rst_after", 1'b1, 1'b1, 1'b1, 8'd1, 1'b0);

        // Random traffic with random back-pressure and biased operand ties.
        for (int n = 0; n < 400; n++) begin
            logic [SE-1:0] ea;
            logic [SE-1:0] eb;
            logic [SM-1:0] ma;
            logic [SM-1:0] mb;
            ea = SE'($urandom);
            eb = ($urandom_range(0, 3) == 0) ? ea : SE'($urandom);
            ma = SM'($urandom);
            mb = ($urandom_range(0, 5) == 0) ? ma : SM'($urandom);
            present(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), ea, ma,
                    1'($urandom), eb, mb);
            i_ready = ($urandom_range(0, 9) < 7);
            i_rst = ($urandom_range(0, 149) == 0);
            tick();
            i_rst = 1'b0;
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
